output_writeback: RTL and testbench
===================================

# output_writeback

Write-back stage downstream of the activation block. It buffers result rows (one `MAT_MUL_SIZE*DWIDTH` row per `in_data_available` pulse) in a small FIFO and writes them into BRAM A (port 0) at `address_mat_c + n*address_stride_c`. Writes go out only in cycles where the BRAM port is granted. It replaces the single flop stage between activation and BRAM A, so pipeline output is never lost while the matmul is reading the same port.

## Interface
- `DWIDTH`, 8, element width in bits
- `MAT_MUL_SIZE`, 4, elements per row
- `MASK_WIDTH`, 4, byte-enable width (= `MAT_MUL_SIZE`)
- `AWIDTH`, 10, BRAM address width
- `ADDR_STRIDE_WIDTH`, 8, stride width
- `FIFO_DEPTH`, 4, buffered rows (power of 2, ≥2)

- `clk`  in  1  clock; reset reset, synchronous, active-high; clock clk
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; latches configuration
- `address_mat_c`  in  AWIDTH  base write address
- `address_stride_c`  in  ADDR_STRIDE_WIDTH  address increment per row
- `num_rows`  in  8  rows to write this run
- `in_data_available`  in  1  row valid from activation
- `in_data`  in  MAT_MUL_SIZE*DWIDTH  row data
- `validity_mask`  in  MASK_WIDTH  per-element write enable for the row
- `bram_grant`  in  1  port 0 free this cycle
- `bram_addr`  out  AWIDTH  write address
- `bram_wdata`  out  MAT_MUL_SIZE*DWIDTH  write data
- `bram_we`  out  MASK_WIDTH  byte enables
- `bram_wdata_available`  out  1  port-0 mux select: high while a write is presented
- `busy`  out  1  state ≠ IDLE
- `done_write`  out  1  one-cycle pulse after the last row is written
- `fifo_overflow`  out  1  sticky; a row was dropped

## Operation
- States: IDLE, ACTIVE, DONE.
- **IDLE**
  - `start`=1 latches `address_mat_c`, `address_stride_c` and `num_rows`; clears the row count, FIFO and `fifo_overflow`.
  - Goes to ACTIVE, or to DONE if `num_rows`=0.
- **ACTIVE**
  - Push: `in_data_available`=1 and FIFO not full stores {`in_data`, `validity_mask`}.
  - Overflow: a push while full with no pop in the same cycle drops the row and sets `fifo_overflow`.
  - Simultaneous push and pop when full: the push is accepted.
  - Pop: FIFO non-empty and `bram_grant`=1 pops one entry. The registered outputs become `bram_addr`=current address, `bram_wdata`=data, `bram_we`=mask, `bram_wdata_available`=1.
  - After each pop: current address += zero-extended stride, modulo 2^AWIDTH (wraps); row count += 1.
  - When the row count reaches the latched `num_rows` on a pop, go to DONE.
- **DONE**
  - Asserts `done_write` for exactly one cycle, flushes FIFO residue (extra rows are discarded without setting overflow), then returns to IDLE.
- **Ignored inputs**
  - `start` is ignored outside IDLE.
  - `in_data_available` is ignored in IDLE and DONE (no push, no overflow).
- **Outputs on non-write cycles:** `bram_we`=0, `bram_wdata_available`=0, `bram_wdata`=0; `bram_addr` holds its last value.
- **Reset:** state IDLE, FIFO empty, all outputs 0, address register = 0. Reset mid-run aborts with no `done_write`.

## Timing
- Latches fill at the `start` edge. The first push is accepted at the next edge.
- Minimum latency, with `bram_grant` held high:
  - `in_data_available` sampled at edge k → pop at edge k+1.
  - `bram_we`/`bram_wdata_available` are high in cycle k+1..k+2.
  - With an empty FIFO, data does not bypass the FIFO.
- Throughput: one row per cycle while granted.
- `bram_grant` is sampled at the pop edge only. Outputs are already registered and do not depend combinationally on the grant.
- `done_write` is high in the cycle after the final write's `bram_we` cycle.
- `busy` is high from the edge after `start` through the `done_write` cycle.
- FIFO full/empty uses pointers one bit wider than log2(`FIFO_DEPTH`).

## Test plan
- **Basic run:** base=0x010, stride=4, num_rows=4, grant=1, four back-to-back rows → writes at 0x010, 0x014, 0x018, 0x01C with full mask. Each write 2 cycles after its input; `done_write` 1 cycle after the last write.
- **Grant withheld:** grant=0 for 6 cycles while 4 rows arrive, then grant=1 → no `bram_we` while grant=0; then 4 consecutive writes in order; `fifo_overflow`=0.
- **Overflow:** `FIFO_DEPTH`=4, grant=0, 5 rows → 5th row dropped, `fifo_overflow`=1. After grant, 4 writes; with num_rows=5, `done_write` is never pulsed until a 5th row arrives.
- **Address wrap:** base=0x3FC, stride=8, num_rows=2 → addresses 0x3FC then 0x004.
- **Mask and edge cases:**
  - `validity_mask`=4'b0011 → `bram_we`=4'b0011.
  - num_rows=0 → `done_write` 2 cycles after `start` with no writes.
  - `start` during ACTIVE → ignored.
- **Reset mid-run:** reset after 2 of 4 writes → all outputs 0 next cycle, `busy`=0, no `done_write`; a fresh `start` then runs normally.

Source files
------------

// File: rtl/output_writeback.sv
// output_writeback: buffers activation result rows in a small FIFO and writes
// them into BRAM A port 0 at base + n*stride, only in cycles where the port is
// granted. Outputs are registered and never depend combinationally on grant.
module output_writeback #(
  parameter int unsigned DWIDTH            = 8,
  parameter int unsigned MAT_MUL_SIZE      = 4,
  parameter int unsigned MASK_WIDTH        = 4,
  parameter int unsigned AWIDTH            = 10,
  parameter int unsigned ADDR_STRIDE_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              address_mat_c,
  input  logic [ADDR_STRIDE_WIDTH-1:0]   address_stride_c,
  input  logic [7:0]                     num_rows,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  input  logic                           bram_grant,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
  output logic [MASK_WIDTH-1:0]          bram_we,
  output logic                           bram_wdata_available,
  output logic                           busy,
  output logic                           done_write,
  output logic                           fifo_overflow
);

  localparam int unsigned ROW_W      = MAT_MUL_SIZE * DWIDTH;
  localparam int unsigned ENTRY_W    = ROW_W + MASK_WIDTH;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_FULL_W = PTR_W + 1;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                       state_q;
  state_t                       state_d;

  // Run configuration latched at start
  logic [CNT_W-1:0]             num_rows_q;
  logic [ADDR_STRIDE_WIDTH-1:0] stride_q;
  logic [AWIDTH-1:0]            cur_addr_q;
  logic [CNT_W-1:0]             row_cnt_q;

  // Row FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [ENTRY_W-1:0]           fifo_mem [FIFO_DEPTH];
  logic [PTR_FULL_W-1:0]        wr_ptr_q;
  logic [PTR_FULL_W-1:0]        rd_ptr_q;
  logic                         fifo_empty_c;
  logic                         fifo_full_c;
  logic [ENTRY_W-1:0]           head_c;

  // Per-cycle control decisions
  logic                         start_c;
  logic                         pop_c;
  logic                         push_c;
  logic                         drop_c;
  logic                         last_pop_c;
  logic                         busy_d;

  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_c       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_rows == 8'd0) ? S_DONE : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (last_pop_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/control decode: push, pop, drop and next busy value
  always_comb begin
    start_c    = 1'b0;
    pop_c      = 1'b0;
    push_c     = 1'b0;
    drop_c     = 1'b0;
    last_pop_c = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_c = start;
      end
      S_ACTIVE: begin
        pop_c      = !fifo_empty_c && bram_grant;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        push_c     = in_data_available && (!fifo_full_c || pop_c);
        drop_c     = in_data_available && fifo_full_c && !pop_c;
        last_pop_c = pop_c && (CNT_W'(row_cnt_q + CNT_W'(1)) == num_rows_q);
      end
      default: begin
      end
    endcase
    // stays high through the cycle that carries done_write
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  // FIFO storage; contents need no reset because pointers gate every read
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {in_data, validity_mask};
    end
  end

  // Configuration, pointers, address walk and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      num_rows_q <= '0;
      stride_q   <= '0;
      cur_addr_q <= '0;
      row_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else if (start_c) begin
      num_rows_q <= num_rows;
      stride_q   <= address_stride_c;
      cur_addr_q <= address_mat_c;
      row_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else if (state_q == S_DONE) begin
      // discard rows that arrived beyond num_rows
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_FULL_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q   <= rd_ptr_q + PTR_FULL_W'(1);
        cur_addr_q <= cur_addr_q + AWIDTH'(stride_q);
        row_cnt_q  <= row_cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered BRAM write port and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_addr            <= '0;
      bram_wdata           <= '0;
      bram_we              <= '0;
      bram_wdata_available <= 1'b0;
      busy                 <= 1'b0;
      done_write           <= 1'b0;
      fifo_overflow        <= 1'b0;
    end else begin
      bram_wdata           <= '0;
      bram_we              <= '0;
      bram_wdata_available <= 1'b0;
      if (pop_c) begin
        bram_addr            <= cur_addr_q;
        bram_wdata           <= head_c[ENTRY_W-1:MASK_WIDTH];
        bram_we              <= head_c[MASK_WIDTH-1:0];
        bram_wdata_available <= 1'b1;
      end
      busy       <= busy_d;
      done_write <= (state_q == S_DONE);
      if (start_c) begin
        fifo_overflow <= 1'b0;
      end else if (drop_c) begin
        fifo_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_writeback.sv
// Testbench for output_writeback: queue-based reference model plus a
// scoreboard monitor comparing every cycle's outputs.
module tb_output_writeback;

  localparam int AW    = 10;
  localparam int SW    = 8;
  localparam int MW    = 4;
  localparam int RW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] address_mat_c;
  logic [SW-1:0] address_stride_c;
  logic [7:0]    num_rows;
  logic          in_data_available;
  logic [RW-1:0] in_data;
  logic [MW-1:0] validity_mask;
  logic          bram_grant;
  logic [AW-1:0] bram_addr;
  logic [RW-1:0] bram_wdata;
  logic [MW-1:0] bram_we;
  logic          bram_wdata_available;
  logic          busy;
  logic          done_write;
  logic          fifo_overflow;

  output_writeback dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .address_mat_c        (address_mat_c),
    .address_stride_c     (address_stride_c),
    .num_rows             (num_rows),
    .in_data_available    (in_data_available),
    .in_data              (in_data),
    .validity_mask        (validity_mask),
    .bram_grant           (bram_grant),
    .bram_addr            (bram_addr),
    .bram_wdata           (bram_wdata),
    .bram_we              (bram_we),
    .bram_wdata_available (bram_wdata_available),
    .busy                 (busy),
    .done_write           (done_write),
    .fifo_overflow        (fifo_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    logic [MW-1:0] mask;
  } wr_t;

  typedef struct {
    logic [RW-1:0] data;
    logic [MW-1:0] mask;
  } row_t;

  wr_t  exp_q[$];
  row_t mq[$];

  int checks = 0;
  int errors = 0;

  // reference model state: 0 idle, 1 active, 2 done
  int            m_state = 0;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_stride;
  int            m_n;
  int            m_cnt;
  logic          e_wr, e_done, e_busy, e_ovf;
  logic [AW-1:0] e_addr;
  bit            m_seen = 0;
  row_t          m_row;
  wr_t           m_wr;
  bit            m_popped;

  // Reference model: rows are a bounded queue, one write per granted cycle
  always @(posedge clk) begin
    m_seen = 1;
    if (reset) begin
      m_state = 0;
      mq.delete();
      exp_q.delete();
      e_wr = 0; e_done = 0; e_busy = 0; e_ovf = 0; e_addr = '0;
    end else begin
      e_wr   = 0;
      e_done = 0;
      case (m_state)
        0: begin
          e_busy = 0;
          if (start) begin
            m_addr   = address_mat_c;
            m_stride = address_stride_c;
            m_n      = num_rows;
            m_cnt    = 0;
            e_ovf    = 0;
            mq.delete();
            m_state  = (num_rows == 0) ? 2 : 1;
            e_busy   = 1;
          end
        end
        1: begin
          e_busy   = 1;
          m_popped = 0;
          if (mq.size() > 0 && bram_grant) begin
            m_row     = mq.pop_front();
            m_wr.addr = m_addr;
            m_wr.data = m_row.data;
            m_wr.mask = m_row.mask;
            exp_q.push_back(m_wr);
            e_addr    = m_addr;
            e_wr      = 1;
            m_addr    = m_addr + {2'b00, m_stride};
            m_cnt++;
            m_popped  = 1;
          end
          if (in_data_available) begin
            if (mq.size() < DEPTH) begin
              m_row.data = in_data;
              m_row.mask = validity_mask;
              mq.push_back(m_row);
            end else begin
              e_ovf = 1;
            end
          end
          if (m_popped && m_cnt == m_n) m_state = 2;
        end
        default: begin
          e_busy  = 1;
          e_done  = 1;
          mq.delete();
          m_state = 0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write
  wr_t got;
  always @(negedge clk) begin
    if (m_seen) begin
      if (bram_wdata_available === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h at %0t", bram_addr, bram_wdata, $time);
        end else begin
          got = exp_q.pop_front();
          check("write_addr", 64'(bram_addr), 64'(got.addr));
          check("write_data", 64'(bram_wdata), 64'(got.data));
          check("write_we", 64'(bram_we), 64'(got.mask));
        end
      end else begin
        check("idle_we", 64'(bram_we), 64'd0);
        check("idle_wdata", 64'(bram_wdata), 64'd0);
      end
      check("wdata_available", 64'(bram_wdata_available), 64'(e_wr));
      check("addr_hold", 64'(bram_addr), 64'(e_addr));
      check("done_write", 64'(done_write), 64'(e_done));
      check("busy", 64'(busy), 64'(e_busy));
      check("fifo_overflow", 64'(fifo_overflow), 64'(e_ovf));
    end
  end

  task automatic step(input logic v, input logic [RW-1:0] d, input logic [MW-1:0] m, input logic g);
    in_data_available = v;
    in_data           = d;
    validity_mask     = m;
    bram_grant        = g;
    @(negedge clk);
  endtask

  task automatic start_run(input logic [AW-1:0] b, input logic [SW-1:0] s, input logic [7:0] n);
    start             = 1'b1;
    address_mat_c     = b;
    address_stride_c  = s;
    num_rows          = n;
    in_data_available = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && m_state != 0; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 4'($urandom), 1'b1);
    end
    if (m_state != 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: model state %0d expected 0", m_state);
    end
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    address_mat_c = '0;
    address_stride_c = '0;
    num_rows = '0;
    in_data_available = 1'b0;
    in_data = '0;
    validity_mask = '0;
    bram_grant = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // basic back-to-back run
    start_run(10'h010, 8'd4, 8'd4);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 4'hF, 1'b1);
    wait_idle(50);

    // grant withheld while rows arrive
    start_run(10'h100, 8'd1, 8'd4);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 4'hF, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b0);
    wait_idle(50);

    // overflow: fifth row dropped, run waits for another row
    start_run(10'h040, 8'd2, 8'd5);
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1);
    check("overflow_sticky", 64'(fifo_overflow), 64'd1);
    check("no_early_done_busy", 64'(busy), 64'd1);
    step(1'b1, $urandom, 4'hF, 1'b1);
    wait_idle(50);

    // address wrap
    start_run(10'h3FC, 8'd8, 8'd2);
    for (int i = 0; i < 2; i++) step(1'b1, $urandom, 4'hF, 1'b1);
    wait_idle(50);

    // partial mask
    start_run(10'h000, 8'd1, 8'd3);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 4'b0011, 1'b1);
    wait_idle(50);

    // zero rows
    start_run(10'h055, 8'd3, 8'd0);
    wait_idle(10);

    // start while active is ignored
    start_run(10'h020, 8'd4, 8'd3);
    step(1'b1, $urandom, 4'hF, 1'b1);
    start = 1'b1; address_mat_c = 10'h200; address_stride_c = 8'd16; num_rows = 8'd9;
    step(1'b1, $urandom, 4'hF, 1'b1);
    start = 1'b0;
    step(1'b1, $urandom, 4'hF, 1'b1);
    wait_idle(50);

    // reset mid-run after two writes, then a fresh run
    start_run(10'h080, 8'd4, 8'd4);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 4'hF, 1'b1);
    reset = 1'b1;
    step(1'b0, '0, '0, 1'b1);
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_addr", 64'(bram_addr), 64'd0);
    step(1'b0, '0, '0, 1'b1);
    start_run(10'h0C0, 8'd4, 8'd4);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 4'hF, 1'b1);
    wait_idle(50);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      start_run(10'($urandom), 8'($urandom), 8'($urandom_range(0, 10)));
      for (int c = 0; c < int'($urandom_range(4, 30)); c++) begin
        step(1'($urandom_range(0, 9) < 6), $urandom, 4'($urandom), 1'($urandom_range(0, 9) < 7));
      end
      wait_idle(300);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
